// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : RV32I opcode constants, class-bit indices and the decode bundle
// Rev 1.0   : initial handshake decode stage release
// ============================================================================
package riscv_pkg;

    localparam int c_XLEN    = 32;
    localparam int c_NUM_CLS = 11;

    localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] c_OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
    localparam logic [6:0] c_OPC_OP      = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI     = 7'b0110111;
    localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR    = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL     = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MUL  = 7'b0000001;

    // Bit positions inside the one-hot dec_class vector
    localparam int c_CLS_LOAD    = 0;
    localparam int c_CLS_OPIMM   = 1;
    localparam int c_CLS_AUIPC   = 2;
    localparam int c_CLS_STORE   = 3;
    localparam int c_CLS_OP      = 4;
    localparam int c_CLS_LUI     = 5;
    localparam int c_CLS_BRANCH  = 6;
    localparam int c_CLS_JALR    = 7;
    localparam int c_CLS_JAL     = 8;
    localparam int c_CLS_SYSTEM  = 9;
    localparam int c_CLS_MISCMEM = 10;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 rs1en;
        logic                 rs2en;
        logic                 rden;
        logic                 immen;
        logic                 pcen;
        logic [c_XLEN-1:0]    imm;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [c_NUM_CLS-1:0] cls;
        logic                 is_m;
        logic                 illegal;
        logic [c_XLEN-1:0]    pc;
    } dec_bundle_t;

    function automatic logic [c_XLEN-1:0] sext12(input logic [11:0] v);
        return {{(c_XLEN-12){v[11]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_decode_comb.sv
`default_nettype none
// ============================================================================
// riscv_decode_comb : combinational RV32I instruction word -> decode bundle
// Rev 1.0           : initial handshake decode stage release
// ============================================================================
module riscv_decode_comb
    import riscv_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_SYS = 1'b1,
    parameter bit ILL_ZERO   = 1'b1
) (
    input  logic [31:0]       i_ir,
    input  logic [c_XLEN-1:0] i_pc,
    output dec_bundle_t       o_dec
);

    logic [6:0]           w_opc;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic [c_NUM_CLS-1:0] w_cls;
    imm_fmt_t             w_fmt;
    logic                 w_ill;
    logic                 w_mul;
    logic                 w_keep;
    logic                 w_rs1en;
    logic                 w_rs2en;
    logic                 w_rden;
    logic                 w_immen;
    logic                 w_pcen;
    logic [c_XLEN-1:0]    w_imm;

    assign w_opc = i_ir[6:0];
    assign w_f3  = i_ir[14:12];
    assign w_f7  = i_ir[31:25];

    always_comb begin
        w_cls = '0;
        w_fmt = IMM_NONE;
        w_ill = 1'b0;
        w_mul = 1'b0;
        case (w_opc)
            c_OPC_LOAD: begin
                w_cls[c_CLS_LOAD] = 1'b1;
                w_fmt = IMM_I;
            end
            c_OPC_OPIMM: begin
                w_cls[c_CLS_OPIMM] = 1'b1;
                w_fmt = IMM_I;
                // Shift immediates reuse the funct7 field; only SRAI may set bit 30
                if (w_f3 == 3'b001 && w_f7 != c_F7_BASE)
                    w_ill = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != c_F7_BASE && w_f7 != c_F7_ALT)
                    w_ill = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_cls[c_CLS_AUIPC] = 1'b1;
                w_fmt = IMM_U;
            end
            c_OPC_STORE: begin
                w_cls[c_CLS_STORE] = 1'b1;
                w_fmt = IMM_S;
            end
            c_OPC_OP: begin
                w_cls[c_CLS_OP] = 1'b1;
                if (w_f7 == c_F7_MUL && ENABLE_M)
                    w_mul = 1'b1;
                else if (w_f7 != c_F7_BASE && w_f7 != c_F7_ALT)
                    w_ill = 1'b1;
            end
            c_OPC_LUI: begin
                w_cls[c_CLS_LUI] = 1'b1;
                w_fmt = IMM_U;
            end
            c_OPC_BRANCH: begin
                w_cls[c_CLS_BRANCH] = 1'b1;
                w_fmt = IMM_B;
            end
            c_OPC_JALR: begin
                w_cls[c_CLS_JALR] = 1'b1;
                w_fmt = IMM_I;
                if (w_f3 != 3'b000)
                    w_ill = 1'b1;
            end
            c_OPC_JAL: begin
                w_cls[c_CLS_JAL] = 1'b1;
                w_fmt = IMM_J;
            end
            c_OPC_SYSTEM: begin
                w_cls[c_CLS_SYSTEM] = 1'b1;
                w_ill = !ENABLE_SYS;
            end
            c_OPC_MISCMEM: begin
                w_cls[c_CLS_MISCMEM] = 1'b1;
                w_ill = !ENABLE_SYS;
            end
            default: w_ill = 1'b1;
        endcase
        if (i_ir[1:0] != 2'b11)
            w_ill = 1'b1;
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_I:   w_imm = sext12(i_ir[31:20]);
            IMM_S:   w_imm = sext12({i_ir[31:25], i_ir[11:7]});
            IMM_B:   w_imm = {{(c_XLEN-12){i_ir[31]}}, i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
            IMM_U:   w_imm = {i_ir[31:12], 12'b0};
            IMM_J:   w_imm = {{(c_XLEN-20){i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Enables come from the raw class so ILL_ZERO alone decides what an illegal word exposes
    assign w_keep  = !(ILL_ZERO && w_ill);
    assign w_pcen  = w_keep & (w_cls[c_CLS_JAL] | w_cls[c_CLS_BRANCH] | w_cls[c_CLS_AUIPC]);
    assign w_rs1en = w_keep & (w_cls[c_CLS_JALR] | w_cls[c_CLS_BRANCH] | w_cls[c_CLS_LOAD]
                             | w_cls[c_CLS_STORE] | w_cls[c_CLS_OP] | w_cls[c_CLS_OPIMM]);
    assign w_rs2en = w_keep & (w_cls[c_CLS_BRANCH] | w_cls[c_CLS_STORE] | w_cls[c_CLS_OP]);
    assign w_rden  = w_keep & (w_cls[c_CLS_LUI] | w_cls[c_CLS_AUIPC] | w_cls[c_CLS_JALR]
                             | w_cls[c_CLS_JAL] | w_cls[c_CLS_LOAD] | w_cls[c_CLS_OP]
                             | w_cls[c_CLS_OPIMM]);
    assign w_immen = w_keep & (w_fmt != IMM_NONE);

    always_comb begin
        o_dec         = '0;
        o_dec.rs1en   = w_rs1en;
        o_dec.rs2en   = w_rs2en;
        o_dec.rden    = w_rden;
        o_dec.immen   = w_immen;
        o_dec.pcen    = w_pcen;
        o_dec.rs1     = w_rs1en ? i_ir[19:15] : 5'd0;
        o_dec.rs2     = w_rs2en ? i_ir[24:20] : 5'd0;
        o_dec.rd      = w_rden  ? i_ir[11:7]  : 5'd0;
        o_dec.imm     = w_immen ? w_imm : '0;
        o_dec.funct3  = w_f3;
        o_dec.funct7  = w_f7;
        o_dec.cls     = w_ill ? '0 : w_cls;
        o_dec.is_m    = w_mul & !w_ill;
        o_dec.illegal = w_ill;
        o_dec.pc      = i_pc;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ============================================================================
// decode_stage_hs : RV32I decode stage, valid/ready on both sides, 2-entry skid
// Rev 1.0         : initial handshake decode stage release
// ============================================================================
module decode_stage_hs
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_SYS = 1'b1,
    parameter bit ILL_ZERO   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [4:0]      dec_rd,
    output logic            dec_rs1en,
    output logic            dec_rs2en,
    output logic            dec_rden,
    output logic            dec_immen,
    output logic            dec_pcen,
    output logic [XLEN-1:0] dec_imm,
    output logic [2:0]      dec_funct3,
    output logic [6:0]      dec_funct7,
    output logic [10:0]     dec_class,
    output logic            dec_is_m,
    output logic            dec_illegal,
    output logic [XLEN-1:0] dec_pc
);

    dec_bundle_t w_dec;
    dec_bundle_t r_main;
    dec_bundle_t r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;
    logic        w_in_fire;
    logic        w_main_free;

    riscv_decode_comb #(
        .ENABLE_M   (ENABLE_M),
        .ENABLE_SYS (ENABLE_SYS),
        .ILL_ZERO   (ILL_ZERO)
    ) u_decode (
        .i_ir  (in_ir),
        .i_pc  (in_pc),
        .o_dec (w_dec)
    );

    assign in_ready    = !r_skid_valid;
    assign w_in_fire   = in_valid && in_ready;
    assign w_main_free = !r_main_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // Skid always refills main before new input so ordering is kept
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_main_valid;
    assign dec_rs1     = r_main.rs1;
    assign dec_rs2     = r_main.rs2;
    assign dec_rd      = r_main.rd;
    assign dec_rs1en   = r_main.rs1en;
    assign dec_rs2en   = r_main.rs2en;
    assign dec_rden    = r_main.rden;
    assign dec_immen   = r_main.immen;
    assign dec_pcen    = r_main.pcen;
    assign dec_imm     = r_main.imm;
    assign dec_funct3  = r_main.funct3;
    assign dec_funct7  = r_main.funct7;
    assign dec_class   = r_main.cls;
    assign dec_is_m    = r_main.is_m;
    assign dec_illegal = r_main.illegal;
    assign dec_pc      = r_main.pc;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_hs : directed checks of decode_stage_hs (ENABLE_M=1 and =0)
// Rev 1.0            : initial release
// ============================================================================
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_ir, in_pc;

    logic        in_ready, out_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rs1en, dec_rs2en, dec_rden, dec_immen, dec_pcen;
    logic [31:0] dec_imm, dec_pc;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [10:0] dec_class;
    logic        dec_is_m, dec_illegal;

    logic        n_in_ready, n_out_valid;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    logic        n_rs1en, n_rs2en, n_rden, n_immen, n_pcen;
    logic [31:0] n_imm, n_pc;
    logic [2:0]  n_funct3;
    logic [6:0]  n_funct7;
    logic [10:0] n_class;
    logic        n_is_m, n_illegal;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_rs1en(dec_rs1en), .dec_rs2en(dec_rs2en), .dec_rden(dec_rden),
        .dec_immen(dec_immen), .dec_pcen(dec_pcen), .dec_imm(dec_imm),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_class(dec_class),
        .dec_is_m(dec_is_m), .dec_illegal(dec_illegal), .dec_pc(dec_pc)
    );

    decode_stage_hs #(.ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .dec_rs1(n_rs1), .dec_rs2(n_rs2), .dec_rd(n_rd),
        .dec_rs1en(n_rs1en), .dec_rs2en(n_rs2en), .dec_rden(n_rden),
        .dec_immen(n_immen), .dec_pcen(n_pcen), .dec_imm(n_imm),
        .dec_funct3(n_funct3), .dec_funct7(n_funct7), .dec_class(n_class),
        .dec_is_m(n_is_m), .dec_illegal(n_illegal), .dec_pc(n_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ir, input logic [31:0] pc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ir = 32'h0; in_pc = 32'h0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc", dec_pc, 0);
        chk("rst_imm", dec_imm, 0);
        chk("rst_class", dec_class, 0);
        chk("rst_funct7", dec_funct7, 0);
        @(negedge clk);
        reset = 1'b0;

        // addi x1,x2,-1
        send(32'hFFF10093, 32'h80);
        chk("addi_valid", out_valid, 1);
        chk("addi_class", dec_class, 11'h002);
        chk("addi_rs1", dec_rs1, 2);
        chk("addi_rd", dec_rd, 1);
        chk("addi_imm", dec_imm, 32'hFFFFFFFF);
        chk("addi_rs2en", dec_rs2en, 0);
        chk("addi_rs2", dec_rs2, 0);
        chk("addi_pc", dec_pc, 32'h80);

        // beq x1,x2,-4
        send(32'hFE208EE3, 32'h100);
        chk("beq_class", dec_class, 11'h040);
        chk("beq_rs1", dec_rs1, 1);
        chk("beq_rs2", dec_rs2, 2);
        chk("beq_imm", dec_imm, 32'hFFFFFFFC);
        chk("beq_pcen", dec_pcen, 1);
        chk("beq_pc", dec_pc, 32'h100);
        chk("beq_rden", dec_rden, 0);
        chk("beq_rd", dec_rd, 0);

        // mul x3,x1,x2 with and without M
        send(32'h022081B3, 32'h104);
        chk("mul_class", dec_class, 11'h010);
        chk("mul_is_m", dec_is_m, 1);
        chk("mul_rd", dec_rd, 3);
        chk("mul_illegal", dec_illegal, 0);
        chk("mul_nom_illegal", n_illegal, 1);
        chk("mul_nom_class", n_class, 0);
        chk("mul_nom_rd", n_rd, 0);
        chk("mul_nom_is_m", n_is_m, 0);

        // lui x1,0x12345
        send(32'h123450B7, 32'h108);
        chk("lui_class", dec_class, 11'h020);
        chk("lui_imm", dec_imm, 32'h12345000);
        chk("lui_rs1en", dec_rs1en, 0);
        // jal x0,8
        send(32'h0080006F, 32'h10C);
        chk("jal_class", dec_class, 11'h100);
        chk("jal_imm", dec_imm, 32'h8);
        chk("jal_pcen", dec_pcen, 1);
        // sw x2,4(x1)
        send(32'h0020A223, 32'h110);
        chk("sw_class", dec_class, 11'h008);
        chk("sw_imm", dec_imm, 32'h4);
        chk("sw_rs1", dec_rs1, 1);
        chk("sw_rs2", dec_rs2, 2);
        chk("sw_rd", dec_rd, 0);
        // jalr with funct3=001
        send(32'h00009067, 32'h114);
        chk("jalr_f3_illegal", dec_illegal, 1);
        chk("jalr_f3_class", dec_class, 0);
        chk("jalr_f3_rs1en", dec_rs1en, 0);
        // srai x1,x1,1 legal, slli with funct7=0100000 illegal
        send(32'h4010D093, 32'h118);
        chk("srai_illegal", dec_illegal, 0);
        chk("srai_imm", dec_imm, 32'h401);
        send(32'h40109093, 32'h11C);
        chk("slli_alt_illegal", dec_illegal, 1);
        // OP with funct7=0010000
        send(32'h202081B3, 32'h120);
        chk("op_f7_illegal", dec_illegal, 1);
        chk("op_f7_nom_illegal", n_illegal, 1);
        chk("op_f7_pc", dec_pc, 32'h120);
        tick();
        chk("idle_out_valid", out_valid, 0);

        // Backpressure: three words, two held, third waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00100093; in_pc = 32'h200;
        tick();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_pc", dec_pc, 32'h200);
        chk("bp_a_in_ready", in_ready, 1);
        in_ir = 32'h00200113; in_pc = 32'h204;
        tick();
        chk("bp_b_in_ready", in_ready, 0);
        chk("bp_b_hold_pc", dec_pc, 32'h200);
        in_ir = 32'h00300193; in_pc = 32'h208;
        tick();
        chk("bp_c_hold_pc", dec_pc, 32'h200);
        chk("bp_c_hold_imm", dec_imm, 32'h1);
        chk("bp_c_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_b_pc", dec_pc, 32'h204);
        chk("bp_rel_b_imm", dec_imm, 32'h2);
        chk("bp_rel_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_rel_c_pc", dec_pc, 32'h208);
        chk("bp_rel_c_imm", dec_imm, 32'h3);
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // Flush with skid full and an input presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00100093; in_pc = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        chk("fl_skid_full", in_ready, 0);
        flush = 1'b1; in_pc = 32'h308;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_none_1", out_valid, 0);
        tick();
        chk("fl_none_2", out_valid, 0);
        send(32'h00400213, 32'h30C);
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_pc", dec_pc, 32'h30C);
        in_valid = 1'b1; in_pc = 32'h310; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_input", out_valid, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00100093; in_pc = 32'h400;
        tick();
        in_pc = 32'h404;
        tick();
        in_valid = 1'b0;
        chk("rs_skid_full", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_in_ready", in_ready, 1);
        chk("rs_pc", dec_pc, 0);
        chk("rs_imm", dec_imm, 0);
        chk("rs_rd", dec_rd, 0);
        chk("rs_rden", dec_rden, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(32'h00000000, 32'h500);
        chk("zero_valid", out_valid, 1);
        chk("zero_illegal", dec_illegal, 1);
        chk("zero_class", dec_class, 0);
        chk("zero_pc", dec_pc, 32'h500);
        chk("zero_imm", dec_imm, 0);
        tick();
        chk("zero_no_dup", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
